uart_block_rx: RTL
==================

UART_BLOCK_RX -- requirements
Module: uart_block_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (100 MHz / 115200 baud); legal values are 4 to 65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port rx, input, 1 bit: asynchronous UART serial line, idle high.
REQ-005 The block SHALL have port block_data, output, 128 bits: the assembled AES state block.
REQ-006 The block SHALL have port block_valid, output, 1 bit: block_data holds an unconsumed block.
REQ-007 The block SHALL have port block_ready, input, 1 bit: the downstream AES byte-substitution stage accepts the block.
REQ-008 The block SHALL have port byte_cnt, output, 4 bits: number of bytes held in the assembly register (0-15).
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a received byte has a low stop bit.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed block is dropped.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; all timing references the synchronized signal.
REQ-012 Receiver FSM states SHALL be IDLE, START, DATA and STOP, with a bit-timer counter and a 3-bit bit index.
REQ-013 IDLE->START SHALL occur on a 1-to-0 transition of synchronized rx; the timer clears.
REQ-014 In START, at timer = CLKS_PER_BIT/2 (integer division): rx low -> DATA with timer cleared; rx high -> IDLE (glitch rejected, no error).
REQ-015 In DATA, each bit SHALL be sampled when the timer reaches CLKS_PER_BIT-1, then the timer clears; bits arrive LSB first; after bit 7 -> STOP.
REQ-016 In STOP, at timer = CLKS_PER_BIT-1: rx high -> byte accepted; rx low -> frame_err pulses for 1 cycle and the byte is discarded; either case -> IDLE.
REQ-017 An accepted byte SHALL be written into the assembly register, with byte n (0-based) at bits [127-8n : 120-8n], so the first byte lands in [127:120]; byte_cnt increments, wrapping 15->0 on the 16th byte.
REQ-018 On the 16th byte, if block_valid=0, or block_valid=1 and block_ready=1 in the same cycle, the full block SHALL be copied to block_data and block_valid SHALL be 1 on the next cycle.
REQ-019 On the 16th byte with block_valid=1 and block_ready=0, the new block SHALL be dropped, overrun SHALL pulse for 1 cycle, and block_data/block_valid SHALL be unchanged.
REQ-020 block_valid SHALL fall the cycle after block_valid & block_ready, unless REQ-018 reloads it in that same cycle.
REQ-021 block_data SHALL be stable while block_valid=1 and block_ready=0.
REQ-022 Latency: block_valid SHALL rise exactly 1 cycle after the stop-bit sample cycle of the 16th byte.
REQ-023 A frame error SHALL NOT change byte_cnt or the partial block.

Reset
REQ-024 While rst=1, the FSM SHALL go to IDLE; timer, bit index and byte_cnt SHALL clear; block_data SHALL be 0; block_valid, frame_err and overrun SHALL be 0; synchronizer flops SHALL be 1.
REQ-025 Reset mid-byte or mid-block SHALL discard all partial data; the next falling edge after release starts a fresh byte 0.

Verification (CLKS_PER_BIT=4)
REQ-026 Send bytes 0x00..0x0F with block_ready held 1 -> block_data=0x000102030405060708090A0B0C0D0E0F, block_valid high 1 cycle, 1 cycle after the last stop sample.
REQ-027 Send byte 0x19 with stop bit low -> frame_err pulses once, byte_cnt stays 0; then send 0x19 correctly -> byte_cnt=1.
REQ-028 rx low pulse lasting 1 cycle (shorter than half a bit) -> FSM returns to IDLE; no byte, no error, byte_cnt=0.
REQ-029 With block_ready=0, send 32 bytes 0xAA then 0x55 -> block_data is all 0xAA, overrun pulses once at the 32nd byte, block_valid stays 1.
REQ-030 16th byte completes in the same cycle block_ready accepts the prior block -> new block loaded, block_valid stays 1, no overrun.
REQ-031 Assert rst after 5 bytes plus 3 data bits -> all outputs 0, byte_cnt=0; next 16 bytes form a correct block.

Source files
------------

// File: rtl/uart_block_rx.sv
// UART receiver that assembles sixteen 8N1 bytes into a 128-bit AES state block,
// first byte in [127:120]. Block handoff is valid/ready; a block that cannot be handed off is dropped.
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | timing to mid start bit to reject glitches
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling stop bit, accept byte or flag frame error
module uart_block_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  output logic [127:0] block_data,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [3:0]   byte_cnt,
  output logic         frame_err,
  output logic         overrun
);

  localparam logic [15:0] T_HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] T_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t       state, state_nxt;
  logic [15:0]  timer, timer_nxt;
  logic [2:0]   bit_idx, bit_idx_nxt;
  logic [7:0]   shift, shift_nxt;
  logic         rx_meta, rx_sync, rx_prev;
  logic         byte_done, stop_bad;
  logic [127:0] asm_q;
  logic [127:0] full_block;
  logic [6:0]   slot_lo;

  // rx_prev is an edge-detect stage behind the two synchronizer flops
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 16'd1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    byte_done   = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt   = '0;
        bit_idx_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = START;
      end
      START: begin
        if (timer == T_HALF) begin
          timer_nxt = '0;
          state_nxt = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == T_LAST) begin
          timer_nxt = '0;
          shift_nxt = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (timer == T_LAST) begin
          timer_nxt = '0;
          state_nxt = IDLE;
          byte_done = rx_sync;
          stop_bad  = !rx_sync;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // byte n lands at bit 8*(15-n), i.e. {~n, 3'b000}
  assign slot_lo    = {~byte_cnt, 3'b000};
  assign full_block = {asm_q[127:8], shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      byte_cnt    <= '0;
      block_data  <= '0;
      block_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (block_valid && block_ready) block_valid <= 1'b0;
      if (byte_done) begin
        asm_q[slot_lo +: 8] <= shift;
        byte_cnt            <= byte_cnt + 4'd1;
        if (byte_cnt == 4'd15) begin
          if (!block_valid || block_ready) begin
            block_data  <= full_block;
            block_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule
